fft_mag_ram_writer: RTL

- Upstream stage of the 2048x32 FFT spectrum RAM (ram_fft) in the oscilloscope path.
- Consumes the complex FFT output stream and computes power magnitude re^2+im^2 per bin.
- Writes one frame of bins into the RAM write port, then holds the frame until the display/readout side acknowledges it.
- Implements an arm / capture / done handshake so the RAM is never overwritten while it is being read.

---
 rtl/fft_mag_ram_writer_pkg.sv | 15 +
 rtl/fft_mag_ram_writer_mag_sq.sv | 85 ++++++++
 rtl/fft_mag_ram_writer.sv | 118 +++++++++++
 3 files changed

// File: rtl/fft_mag_ram_writer_pkg.sv
// Shared constants and FSM encoding for the FFT magnitude writer and its ram_fft instance.
package fft_mag_ram_writer_pkg;

  localparam int ADDR_WIDTH_C = 11;
  localparam int DATA_WIDTH_C = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/fft_mag_ram_writer_mag_sq.sv
// Two-stage registered power magnitude re^2+im^2 with output shift; valid and bin address travel alongside.
module fft_mag_sq
  import fft_mag_ram_writer_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = ADDR_WIDTH_C,
  parameter int DATA_WIDTH = DATA_WIDTH_C,
  parameter int MAG_SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic signed [IN_WIDTH-1:0]  in_re,
  input  logic signed [IN_WIDTH-1:0]  in_im,
  output logic                        out_valid,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0]       out_data
);

  localparam int SQ_W  = 2 * IN_WIDTH;
  localparam int SUM_W = SQ_W + 1;

  logic                    s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
  logic [SQ_W-1:0]         re_sq_q, re_sq_d;
  logic [SQ_W-1:0]         im_sq_q, im_sq_d;
  logic                    out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic signed [SQ_W-1:0]       re_ext, im_ext;
  logic [SUM_W-1:0]             sum;
  logic [SUM_W+DATA_WIDTH-1:0]  sum_wide;

  always_comb begin
    re_ext      = SQ_W'(in_re);
    im_ext      = SQ_W'(in_im);
    s1_valid_d  = in_valid;
    s1_addr_d   = s1_addr_q;
    re_sq_d     = re_sq_q;
    im_sq_d     = im_sq_q;
    if (in_valid) begin
      s1_addr_d = in_addr;
      re_sq_d   = re_ext * re_ext;
      im_sq_d   = im_ext * im_ext;
    end

    // One extra sum bit keeps 2*(-2^(IN_WIDTH-1))^2 exact before shift/resize.
    sum         = {1'b0, re_sq_q} + {1'b0, im_sq_q};
    sum_wide    = {{DATA_WIDTH{1'b0}}, (sum >> MAG_SHIFT)};
    out_valid_d = s1_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (s1_valid_q) begin
      out_addr_d = s1_addr_q;
      out_data_d = sum_wide[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      re_sq_q     <= '0;
      im_sq_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      re_sq_q     <= re_sq_d;
      im_sq_q     <= im_sq_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/fft_mag_ram_writer.sv
// Captures one frame of FFT power magnitudes into the spectrum RAM and holds it until the reader acks.
// fft_valid has no ready: a sample is consumed in the cycle fft_valid is high (fft_last only counts with it).
module fft_mag_ram_writer
  import fft_mag_ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_C,
  parameter int IN_WIDTH   = 16,
  parameter int DATA_WIDTH = DATA_WIDTH_C,
  parameter int MAG_SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fft_valid,
  input  logic                        fft_last,
  input  logic signed [IN_WIDTH-1:0]  fft_re,
  input  logic signed [IN_WIDTH-1:0]  fft_im,
  input  logic                        cap_start,
  input  logic                        frame_ack,
  input  logic                        err_clr,
  output logic                        cap_busy,
  output logic                        frame_done,
  output logic                        err_len,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic [2:0]                  dbg_state
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] bin_cnt_q, bin_cnt_d;
  logic                  flush_q, flush_d;
  logic                  err_len_q, err_len_d;
  logic                  cap_busy_q, cap_busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  accept, last_bin, err_set;

  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    flush_d   = flush_q;
    err_set   = 1'b0;
    accept    = (state_q == ST_CAPTURE) && fft_valid;
    last_bin  = &bin_cnt_q;

    case (state_q)
      ST_IDLE: if (cap_start) state_d = ST_ARM;
      ST_ARM: begin
        // Only the sample after a frame boundary may start a capture.
        if (fft_valid && fft_last) begin
          state_d   = ST_CAPTURE;
          bin_cnt_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (fft_valid) begin
          bin_cnt_d = bin_cnt_q + 1'b1;
          if (fft_last || last_bin) begin
            state_d   = ST_FLUSH;
            bin_cnt_d = '0;
            flush_d   = 1'b0;
            err_set   = fft_last != last_bin;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q) state_d = ST_DONE;
        else         flush_d = 1'b1;
      end
      ST_DONE: if (frame_ack) state_d = cap_start ? ST_ARM : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    err_len_d    = err_set ? 1'b1 : (err_clr ? 1'b0 : err_len_q);
    cap_busy_d   = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bin_cnt_q    <= '0;
      flush_q      <= 1'b0;
      err_len_q    <= 1'b0;
      cap_busy_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      flush_q      <= flush_d;
      err_len_q    <= err_len_d;
      cap_busy_q   <= cap_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  fft_mag_sq #(
    .IN_WIDTH   (IN_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAG_SHIFT  (MAG_SHIFT)
  ) u_mag_sq (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_addr   (bin_cnt_q),
    .in_re     (fft_re),
    .in_im     (fft_im),
    .out_valid (wr_en),
    .out_addr  (wr_addr),
    .out_data  (wr_data)
  );

  assign cap_busy   = cap_busy_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign dbg_state  = state_q;

endmodule
